// File: rtl/sync_fifo_if.sv
// sync_fifo_if: data, handshake, flag and status bundle between a FIFO and its user
interface sync_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);
  logic             clear;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  modport master (
    output clear, write, read, data_in,
    input  data_out, valid, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
  modport slave (
    input  clear, write, read, data_in,
    output data_out, valid, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: any-depth synchronous FIFO with FWFT/registered read, flush and sticky error flags
module sync_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 1
) (
  input logic      CLOCK_50,
  input logic      RST,
  sync_fifo_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d, head;
  logic             ovf_q, ovf_d, unf_q, unf_d, valid_q, valid_d;
  logic             empty, full, rd_ok, wr_ok;
  assign empty = count_q == '0;
  assign full  = count_q == CW'(DEPTH);
  assign head  = mem[rd_ptr_q];
  // clear masks both requests so a flush never moves data or raises errors
  always_comb begin
    rd_ok    = bus.read & ~empty & ~bus.clear;
    wr_ok    = bus.write & (~full | bus.read) & ~bus.clear;
    wr_ptr_d = bus.clear ? '0 : wr_ok ? (wr_ptr_q == AW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = bus.clear ? '0 : rd_ok ? (rd_ptr_q == AW'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = bus.clear ? '0 : (wr_ok & ~rd_ok) ? count_q + 1'b1 : (rd_ok & ~wr_ok) ? count_q - 1'b1 : count_q;
    ovf_d    = ~bus.clear & (ovf_q | (bus.write & ~wr_ok));
    unf_d    = ~bus.clear & (unf_q | (bus.read & ~rd_ok));
    valid_d  = rd_ok;
    dout_d   = bus.clear ? '0 : rd_ok ? head : dout_q;
  end
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (wr_ok) mem[wr_ptr_q] <= bus.data_in;
  end
  // in FWFT mode an empty FIFO shows zero so stale RAM never leaks onto data_out
  assign bus.data_out     = FWFT != 0 ? (empty ? '0 : head) : dout_q;
  assign bus.valid        = FWFT != 0 ? ~empty : valid_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = count_q <= CW'(AE_LEVEL);
  assign bus.almost_full  = count_q >= CW'(AF_LEVEL);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for an FWFT and a registered-read sync_fifo, both DEPTH=10
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] exp_d;
  always #5 clk = ~clk;
  sync_fifo_if #(.WIDTH(32), .DEPTH(10)) a ();
  sync_fifo_if #(.WIDTH(32), .DEPTH(10)) b ();
  sync_fifo #(.WIDTH(32), .DEPTH(10), .FWFT(1)) dut_a (.CLOCK_50(clk), .RST(rst), .bus(a));
  sync_fifo #(.WIDTH(32), .DEPTH(10), .FWFT(0)) dut_b (.CLOCK_50(clk), .RST(rst), .bus(b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a.clear = 0; a.write = 0; a.read = 0; a.data_in = '0;
    b.clear = 0; b.write = 0; b.read = 0; b.data_in = '0;
  endtask

  task automatic clear_a();
    a.clear = 1;
    tick();
    a.clear = 0;
    qa.delete();
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1;
    #3;
    tests++;
    if ({a.count, a.empty, a.full, a.almost_empty, a.almost_full, a.valid, a.overflow, a.underflow} !== {4'd0, 7'b1010000}) begin
      fails++;
      $display("FAIL reset_flags_a got cnt=%0d e=%b f=%b ae=%b af=%b v=%b ov=%b un=%b", a.count, a.empty, a.full, a.almost_empty, a.almost_full, a.valid, a.overflow, a.underflow);
    end
    tests++;
    if (a.data_out !== 32'h0 || b.data_out !== 32'h0 || b.valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_data got a=%h b=%h bvalid=%b expected 0 0 0", a.data_out, b.data_out, b.valid);
    end
    tick();
    rst = 0;
    tick();
    a.write = 1; a.data_in = 32'hA5A5_A5A5; qa.push_back(32'hA5A5_A5A5);
    tick();
    a.write = 0;
    exp_d = qa[0];
    tests++;
    if (a.count !== 4'd1 || a.empty !== 1'b0 || a.valid !== 1'b1 || a.data_out !== exp_d) begin
      fails++;
      $display("FAIL first_write got cnt=%0d e=%b v=%b d=%h expected 1 0 1 %h", a.count, a.empty, a.valid, a.data_out, exp_d);
    end
    a.read = 1;
    tick();
    a.read = 0;
    void'(qa.pop_front());
    tests++;
    if (a.empty !== 1'b1 || a.data_out !== 32'h0) begin
      fails++;
      $display("FAIL first_read got e=%b d=%h expected 1 0", a.empty, a.data_out);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 10; i++) begin
      a.write = 1; a.data_in = 32'(i); qa.push_back(32'(i));
      tick();
      tests++;
      if (a.count !== 4'(i + 1) || a.almost_full !== (i + 1 >= 8) || a.full !== (i == 9)) begin
        fails++;
        $display("FAIL fill_%0d got cnt=%0d af=%b f=%b", i, a.count, a.almost_full, a.full);
      end
    end
    a.data_in = 32'hDEAD;
    tick();
    a.write = 0;
    tests++;
    if (a.overflow !== 1'b1 || a.count !== 4'd10 || a.underflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow got ov=%b cnt=%0d un=%b expected 1 10 0", a.overflow, a.count, a.underflow);
    end
    for (int i = 0; i < 10; i++) begin
      exp_d = qa.pop_front();
      tests++;
      if (a.data_out !== exp_d || a.valid !== 1'b1) begin
        fails++;
        $display("FAIL drain_%0d got d=%h v=%b expected %h 1", i, a.data_out, a.valid, exp_d);
      end
      a.read = 1;
      tick();
      a.read = 0;
    end
    tests++;
    if (a.empty !== 1'b1 || a.almost_empty !== 1'b1 || a.count !== 4'd0) begin
      fails++;
      $display("FAIL drained got e=%b ae=%b cnt=%0d expected 1 1 0", a.empty, a.almost_empty, a.count);
    end
    clear_a();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      a.write = 1; a.data_in = 32'(100 + i); qa.push_back(32'(100 + i));
      tick();
    end
    a.read = 1;
    for (int i = 0; i < 25; i++) begin
      exp_d = qa.pop_front();
      tests++;
      if (a.data_out !== exp_d) begin
        fails++;
        $display("FAIL b2b_data_%0d got %h expected %h", i, a.data_out, exp_d);
      end
      a.data_in = 32'h77 + 32'(i); qa.push_back(32'h77 + 32'(i));
      tick();
      tests++;
      if (a.count !== 4'd10 || a.full !== 1'b1 || a.overflow !== 1'b0) begin
        fails++;
        $display("FAIL b2b_cnt_%0d got cnt=%0d f=%b ov=%b expected 10 1 0", i, a.count, a.full, a.overflow);
      end
    end
    a.write = 0;
    while (qa.size() > 0) begin
      exp_d = qa.pop_front();
      tests++;
      if (a.data_out !== exp_d) begin
        fails++;
        $display("FAIL b2b_drain got %h expected %h", a.data_out, exp_d);
      end
      tick();
    end
    a.read = 0;
    tests++;
    if (a.empty !== 1'b1 || a.underflow !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end got e=%b un=%b expected 1 0", a.empty, a.underflow);
    end
  endtask

  task automatic test_empty_rw();
    a.read = 1; a.write = 1; a.data_in = 32'h11; qa.push_back(32'h11);
    tick();
    a.read = 0; a.write = 0;
    tests++;
    if (a.count !== 4'd1 || a.underflow !== 1'b1 || a.overflow !== 1'b0) begin
      fails++;
      $display("FAIL empty_rw got cnt=%0d un=%b ov=%b expected 1 1 0", a.count, a.underflow, a.overflow);
    end
    tick();
    exp_d = qa.pop_front();
    tests++;
    if (a.data_out !== exp_d || a.valid !== 1'b1) begin
      fails++;
      $display("FAIL empty_rw_data got %h v=%b expected %h 1", a.data_out, a.valid, exp_d);
    end
    a.read = 1;
    tick();
    a.read = 0;
    clear_a();
  endtask

  task automatic test_fwft0();
    b.write = 1; b.data_in = 32'h3C; qb.push_back(32'h3C);
    tick();
    b.write = 0;
    tests++;
    if (b.valid !== 1'b0 || b.count !== 4'd1) begin
      fails++;
      $display("FAIL fwft0_pre got v=%b cnt=%0d expected 0 1", b.valid, b.count);
    end
    b.read = 1;
    tick();
    b.read = 0;
    exp_d = qb.pop_front();
    tests++;
    if (b.valid !== 1'b1 || b.data_out !== exp_d) begin
      fails++;
      $display("FAIL fwft0_read got v=%b d=%h expected 1 %h", b.valid, b.data_out, exp_d);
    end
    tick();
    tests++;
    if (b.valid !== 1'b0 || b.data_out !== exp_d) begin
      fails++;
      $display("FAIL fwft0_hold got v=%b d=%h expected 0 %h", b.valid, b.data_out, exp_d);
    end
    for (int i = 0; i < 3; i++) begin
      b.write = 1; b.data_in = 32'hB000 + 32'(i); qb.push_back(32'hB000 + 32'(i));
      tick();
    end
    b.write = 0; b.read = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_d = qb.pop_front();
      tests++;
      if (b.valid !== 1'b1 || b.data_out !== exp_d) begin
        fails++;
        $display("FAIL fwft0_stream_%0d got v=%b d=%h expected 1 %h", i, b.valid, b.data_out, exp_d);
      end
    end
    b.read = 0;
  endtask

  task automatic test_clear();
    a.read = 1;
    tick();
    a.read = 0;
    for (int i = 0; i < 6; i++) begin
      a.write = 1; a.data_in = 32'hC0 + 32'(i);
      tick();
    end
    tests++;
    if (a.count !== 4'd6 || a.underflow !== 1'b1) begin
      fails++;
      $display("FAIL clear_pre got cnt=%0d un=%b expected 6 1", a.count, a.underflow);
    end
    a.clear = 1;
    tick();
    a.clear = 0; a.write = 0;
    tests++;
    if (a.count !== 4'd0 || a.empty !== 1'b1 || a.overflow !== 1'b0 || a.underflow !== 1'b0 || a.valid !== 1'b0) begin
      fails++;
      $display("FAIL clear got cnt=%0d e=%b ov=%b un=%b v=%b expected 0 1 0 0 0", a.count, a.empty, a.overflow, a.underflow, a.valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      a.write = 1; b.write = 1; a.data_in = 32'hE0 + 32'(i); b.data_in = 32'hF0 + 32'(i);
      tick();
    end
    a.write = 0; b.write = 0; b.read = 1;
    tick();
    tests++;
    if (b.valid !== 1'b1 || b.data_out !== 32'hF0) begin
      fails++;
      $display("FAIL mid_inflight got v=%b d=%h expected 1 000000f0", b.valid, b.data_out);
    end
    #2 rst = 1;
    #1;
    tests++;
    if (a.count !== 4'd0 || a.empty !== 1'b1 || a.valid !== 1'b0 || b.valid !== 1'b0 || b.data_out !== 32'h0 || b.count !== 4'd0) begin
      fails++;
      $display("FAIL mid_reset got acnt=%0d ae=%b av=%b bv=%b bd=%h bcnt=%0d", a.count, a.empty, a.valid, b.valid, b.data_out, b.count);
    end
    b.read = 0;
    tick();
    rst = 0;
    tick();
    tests++;
    if (a.empty !== 1'b1 || b.empty !== 1'b1 || b.valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset got ae=%b be=%b bv=%b expected 1 1 0", a.empty, b.empty, b.valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_empty_rw();
    test_fwft0();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised synchronous FIFO that replaces the fixed-mode FIFO used between the CPU core and the peripheral/UART paths. It adds arbitrary (non-power-of-two) depth, a full-depth occupancy count, programmable almost-full/almost-empty flags, selectable first-word-fall-through or registered-read mode, correct simultaneous read/write handling, a synchronous flush, and sticky overflow/underflow error flags. Single clock domain.

## Interface
- WIDTH, 32, data item width in bits (≥1)
- DEPTH, 16, number of storage entries (≥2, any integer)
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- FWFT, 1, 1 = head item visible on data_out while not empty; 0 = data_out loaded one cycle after an accepted read

- CLOCK_50  in  1  clock, all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush, active-high
- data_in  in  WIDTH  write data
- write  in  1  write request
- read  in  1  read/pop request
- data_out  out  WIDTH  read data
- valid  out  1  data_out holds a valid item
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AE_LEVEL
- almost_full  out  1  count ≥ AF_LEVEL
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Pointers wr_ptr, rd_ptr: width $clog2(DEPTH), wrap explicitly from DEPTH-1 to 0 (never rely on natural overflow).
- rd_ok = read & ~empty. wr_ok = write & (~full | read). Full + read + write: both accepted, count unchanged.
- Empty + read + write: write accepted, read rejected (no pass-through), underflow set.
- count next: +1 if wr_ok & ~rd_ok; −1 if rd_ok & ~wr_ok; unchanged otherwise.
- overflow set when write & ~wr_ok; underflow set when read & ~rd_ok. Cleared only by RST or clear.
- Flags empty/full/almost_* derived from registered count (combinational compare, no extra latency beyond count).
- FWFT=1: data_out = mem[rd_ptr]; valid = ~empty. read pops the displayed item.
- FWFT=0: on rd_ok, data_out <= mem[rd_ptr], valid <= 1 next cycle; otherwise valid <= 0, data_out holds last value.
- clear: next edge returns all state to reset values; overrides write/read in the same cycle (neither accepted, no error flags set).
- Storage array not reset (RAM-inferable); contents undefined after reset/clear but never observable as valid.
- Reset mid-operation: all state forced immediately (asynchronous); in-flight FWFT=0 read data is discarded.

## Timing
- Reset values: count 0, empty 1, full 0, almost_empty 1, almost_full 0 (1 only if AF_LEVEL==0), valid 0, data_out 0, overflow 0, underflow 0, pointers 0.
- Write-to-visible latency: FWFT=1, written item on data_out and valid=1 the cycle after the write edge; FWFT=0, one further cycle after the read edge.
- Read latency FWFT=0: data_out/valid update on the edge that accepts the read.
- Throughput: one write and one read per cycle, including at full and at DEPTH-1 wrap.
- count, flags update on the same edge as the accepted operation.

## Test plan
- Reset then idle: all outputs at reset values; write 0xA5A5A5A5 once -> count 1, empty 0, FWFT=1 data_out 0xA5A5A5A5 valid 1 next cycle.
- DEPTH=10: write 0..9 -> full=1, count 10, almost_full from count 8; 11th write -> rejected, overflow=1, count stays 10; read 10 -> data 0..9 in order, empty=1.
- Full with simultaneous read+write of 0x77 for 25 cycles (DEPTH=10, pointers wrap ≥2 times) -> count stays 10, order preserved, no overflow.
- Empty with read+write 0x11 -> count 1, underflow=1, 0x11 later read out intact.
- FWFT=0: write 0x3C, read on next cycle -> data_out 0x3C, valid=1 exactly one cycle after read; valid=0 following cycle.
- Fill to 6, assert clear with write=1 -> count 0, empty=1, overflow/underflow 0; assert RST mid-stream -> outputs at reset values before next clock edge.
